// File: rtl/vga_pkg.sv
// Default 800x600 @ 60 Hz (40 MHz pixel clock) timing constants and shared helpers
// for the VGA timing source.
package vga_pkg;

    localparam int COUNT_W = 11;

    localparam int VGA_H_VISIBLE     = 800;
    localparam int VGA_H_FRONT_PORCH = 40;
    localparam int VGA_H_SYNC        = 128;
    localparam int VGA_H_BACK_PORCH  = 88;
    localparam int VGA_V_VISIBLE     = 600;
    localparam int VGA_V_FRONT_PORCH = 1;
    localparam int VGA_V_SYNC        = 4;
    localparam int VGA_V_BACK_PORCH  = 23;

    localparam int VGA_H_TOTAL      = VGA_H_VISIBLE + VGA_H_FRONT_PORCH + VGA_H_SYNC + VGA_H_BACK_PORCH;
    localparam int VGA_H_BLNK_START = VGA_H_VISIBLE;
    localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT_PORCH;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;

    localparam int VGA_V_TOTAL      = VGA_V_VISIBLE + VGA_V_FRONT_PORCH + VGA_V_SYNC + VGA_V_BACK_PORCH;
    localparam int VGA_V_BLNK_START = VGA_V_VISIBLE;
    localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT_PORCH;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    // Eight vertical colour bars, white first, black last.
    function automatic logic [11:0] bar_colour(input logic [2:0] sel);
        case (sel)
            3'd0:    return 12'hFFF;
            3'd1:    return 12'hFF0;
            3'd2:    return 12'h0FF;
            3'd3:    return 12'h0F0;
            3'd4:    return 12'hF0F;
            3'd5:    return 12'hF00;
            3'd6:    return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/vga_if.sv
// Pixel-position stream shared by the timing source and the drawing stages.
interface vga_if;
    import vga_pkg::*;

    logic [COUNT_W-1:0] hcount;
    logic [COUNT_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
    logic [11:0]        rgb;

    modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus registered sync/blank decode of
// the next count, so decode and count land in the same register stage.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = VGA_H_TOTAL,
    parameter int BLNK_START = VGA_H_BLNK_START,
    parameter int SYNC_START = VGA_H_SYNC_START,
    parameter int SYNC_END   = VGA_H_SYNC_END
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [COUNT_W-1:0] count,
    output logic               wrap,
    output logic               sync,
    output logic               blnk
);

    localparam logic [COUNT_W-1:0] LAST       = COUNT_W'(TOTAL - 1);
    localparam logic [COUNT_W-1:0] BLNK_C     = COUNT_W'(BLNK_START);
    localparam logic [COUNT_W-1:0] SYNC_FIRST = COUNT_W'(SYNC_START);
    localparam logic [COUNT_W-1:0] SYNC_LAST  = COUNT_W'(SYNC_END - 1);

    logic [COUNT_W-1:0] count_q, count_d;
    logic               sync_q, sync_d;
    logic               blnk_q, blnk_d;

    // Combinational: tells the next axis that this edge wraps.
    assign wrap = en && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = wrap ? '0 : count_q + COUNT_W'(1);
        end
        sync_d = (count_d >= SYNC_FIRST) && (count_d <= SYNC_LAST);
        blnk_d = (count_d >= BLNK_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            sync_q  <= 1'b0;
            blnk_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
            blnk_q  <= blnk_d;
        end
    end

    assign count = count_q;
    assign sync  = sync_q;
    assign blnk  = blnk_q;

endmodule

// File: rtl/vga_timing.sv
// VGA timing source: registered, mutually aligned position/sync/blank stream plus frame_start.
// Define VGA_TIMING_TEST_PATTERN_EN to drive 8 colour bars on rgb instead of constant black.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE     = VGA_H_VISIBLE,
    parameter int H_FRONT_PORCH = VGA_H_FRONT_PORCH,
    parameter int H_SYNC        = VGA_H_SYNC,
    parameter int H_BACK_PORCH  = VGA_H_BACK_PORCH,
    parameter int V_VISIBLE     = VGA_V_VISIBLE,
    parameter int V_FRONT_PORCH = VGA_V_FRONT_PORCH,
    parameter int V_SYNC        = VGA_V_SYNC,
    parameter int V_BACK_PORCH  = VGA_V_BACK_PORCH
) (
    input  logic   clk,
    input  logic   rst,
    vga_if.vga_out vga_out,
    output logic   frame_start
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT_PORCH;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT_PORCH;

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_width_check
        $error("vga_timing: H_TOTAL/V_TOTAL do not fit the 11-bit counters");
    end

    logic [COUNT_W-1:0] hcount, vcount;
    logic               h_wrap, v_wrap;
    logic               hsync, vsync, hblnk, vblnk;
    logic               frame_start_q;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .BLNK_START (H_VISIBLE),
        .SYNC_START (H_SYNC_START),
        .SYNC_END   (H_SYNC_START + H_SYNC)
    ) u_hcnt (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .count (hcount),
        .wrap  (h_wrap),
        .sync  (hsync),
        .blnk  (hblnk)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .BLNK_START (V_VISIBLE),
        .SYNC_START (V_SYNC_START),
        .SYNC_END   (V_SYNC_START + V_SYNC)
    ) u_vcnt (
        .clk   (clk),
        .rst   (rst),
        .en    (h_wrap),
        .count (vcount),
        .wrap  (v_wrap),
        .sync  (vsync),
        .blnk  (vblnk)
    );

    // A vertical wrap implies a horizontal wrap: the next edge lands on (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= v_wrap;
        end
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam logic [COUNT_W-1:0] H_BLNK_C = COUNT_W'(H_VISIBLE);
    localparam logic [COUNT_W-1:0] V_BLNK_C = COUNT_W'(V_VISIBLE);

    logic [COUNT_W-1:0] hcount_d, vcount_d;
    logic [11:0]        rgb_q, rgb_d;

    // Recompute the next position here so the colour registers alongside the counters.
    always_comb begin
        hcount_d = h_wrap ? '0 : hcount + COUNT_W'(1);
        vcount_d = vcount;
        if (h_wrap) begin
            vcount_d = v_wrap ? '0 : vcount + COUNT_W'(1);
        end
        rgb_d = 12'h000;
        if (hcount_d < H_BLNK_C && vcount_d < V_BLNK_C) begin
            rgb_d = bar_colour(hcount_d[9:7]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= 12'h000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign vga_out.rgb = rgb_q;
`else
    assign vga_out.rgb = 12'h000;
`endif

    assign vga_out.hcount = hcount;
    assign vga_out.vcount = vcount;
    assign vga_out.hsync  = hsync;
    assign vga_out.vsync  = vsync;
    assign vga_out.hblnk  = hblnk;
    assign vga_out.vblnk  = vblnk;
    assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a shrunken-timing instance covers whole frames, the default
// 800x600 instance covers real line timing; both are scored against a cycle-count model.
module tb_vga_timing;

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        fs;
    } obs_t;

    localparam int SHV = 20, SHFP = 4, SHS = 6, SHBP = 5;
    localparam int SVV = 10, SVFP = 1, SVS = 2, SVBP = 3;

    logic clk;
    logic rst;
    logic fs_s, fs_d;

    vga_if vif_s();
    vga_if vif_d();

    vga_timing #(
        .H_VISIBLE     (SHV),
        .H_FRONT_PORCH (SHFP),
        .H_SYNC        (SHS),
        .H_BACK_PORCH  (SHBP),
        .V_VISIBLE     (SVV),
        .V_FRONT_PORCH (SVFP),
        .V_SYNC        (SVS),
        .V_BACK_PORCH  (SVBP)
    ) dut_s (
        .clk         (clk),
        .rst         (rst),
        .vga_out     (vif_s),
        .frame_start (fs_s)
    );

    vga_timing dut_d (
        .clk         (clk),
        .rst         (rst),
        .vga_out     (vif_d),
        .frame_start (fs_d)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          k = 0;
    obs_t        q_s[$];
    obs_t        q_d[$];
    logic [11:0] bars [8];

    // Expected outputs after kk edges out of reset, straight from the timing rules.
    function automatic obs_t model(input int kk, input int hv, input int hfp, input int hs,
                                   input int hbp, input int vv, input int vfp, input int vs,
                                   input int vbp);
        obs_t o;
        int ht = hv + hfp + hs + hbp;
        int vt = vv + vfp + vs + vbp;
        int hc = kk % ht;
        int vc = (kk / ht) % vt;
        o.hc  = 11'(hc);
        o.vc  = 11'(vc);
        o.hb  = (hc >= hv);
        o.hs  = (hc >= hv + hfp) && (hc < hv + hfp + hs);
        o.vb  = (vc >= vv);
        o.vs  = (vc >= vv + vfp) && (vc < vv + vfp + vs);
        o.fs  = (kk > 0) && (kk % (ht * vt) == 0);
        o.rgb = 12'h000;
`ifdef VGA_TIMING_TEST_PATTERN_EN
        if (!o.hb && !o.vb) o.rgb = bars[(hc / 128) % 8];
`endif
        return o;
    endfunction

    function automatic obs_t cur_s();
        return {vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync,
                vif_s.hblnk, vif_s.vblnk, vif_s.rgb, fs_s};
    endfunction

    function automatic obs_t cur_d();
        return {vif_d.hcount, vif_d.vcount, vif_d.hsync, vif_d.vsync,
                vif_d.hblnk, vif_d.vblnk, vif_d.rgb, fs_d};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h fs=%b expected hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h fs=%b",
                     name, k, act.hc, act.vc, act.hs, act.vs, act.hb, act.vb, act.rgb, act.fs,
                     exp.hc, exp.vc, exp.hs, exp.vs, exp.hb, exp.vb, exp.rgb, exp.fs);
        end
    endtask

    // Producer: one expected observation per instance per clock edge.
    always @(posedge clk) begin
        if (rst) k = 0;
        else     k = k + 1;
        q_s.push_back(model(k, SHV, SHFP, SHS, SHBP, SVV, SVFP, SVS, SVBP));
        q_d.push_back(model(k, 800, 40, 128, 88, 600, 1, 4, 23));
    end

    // Monitor: the stream presents a new position every cycle; sample mid-cycle.
    always @(negedge clk) begin
        if (q_s.size() == 0 || q_d.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty got %0d/%0d entries expected at least 1", q_s.size(), q_d.size());
        end else begin
            check("small_stream", cur_s(), q_s.pop_front());
            check("dflt_stream", cur_d(), q_d.pop_front());
        end
    end

    // Raise reset between edges and confirm outputs clear before the next edge.
    task automatic async_reset(input int hold);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_small", cur_s(), '0);
        check("async_rst_dflt", cur_d(), '0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        clk  = 1'b0;
        rst  = 1'b1;
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2500) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            async_reset(int'($urandom_range(1, 4)));
            repeat (int'($urandom_range(40, 1500))) @(posedge clk);
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
